// File: rtl/wei_buf_rd_pkg.sv
// Shared definitions for the weight buffer and the weight cache side of its read port.
// Holds the FSM state encoding and the default data/address widths.
package wei_buf_rd_pkg;

  localparam int WBF_DATA_WIDTH = 8;
  localparam int WBF_ADDR_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_WORK = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    WORK = ST_WORK
  } wbf_state_t;

endpackage

// File: rtl/wei_buf_ofifo.sv
// Two-entry synchronous output FIFO for weight read responses.
// Flush has priority over push and pop.
module wei_buf_ofifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && !flush && (wr_ptr_reg == 1'(gi))) mem[gi] <= din;
      end
    end
  endgenerate

endmodule

// File: rtl/wei_buf_rd.sv
// Weight buffer: filled sequentially from the GLB, then serves in-order single-word
// reads to the weight cache with 1-cycle latency and full backpressure.
module wei_buf_rd
  import wei_buf_rd_pkg::*;
#(
  parameter int DATA_WIDTH     = WBF_DATA_WIDTH,
  parameter int WEI_ADDR_WIDTH = WBF_ADDR_WIDTH,
  parameter int ISA_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      TOPWBF_CfgVld,
  input  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum,
  output logic                      WBFTOP_CfgRdy,
  input  logic                      GLBWBF_DatVld,
  input  logic [DATA_WIDTH-1:0]     GLBWBF_Dat,
  output logic                      WBFGLB_DatRdy,
  input  logic                      WCAWBF_AdrVld,
  input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
  output logic                      WBFWCA_AdrRdy,
  output logic                      WBFWCA_DatVld,
  output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
  input  logic                      WCAWBF_DatRdy
);

  localparam int DEPTH = 2 ** WEI_ADDR_WIDTH;

  // Config word width is reserved for future opcodes; nothing is decoded yet.
  generate
    if (ISA_WIDTH > 0) begin : g_isa_reserved
    end
  endgenerate

  wbf_state_t                state_reg, state_next;
  logic [WEI_ADDR_WIDTH:0]   fill_num_reg;
  logic [WEI_ADDR_WIDTH:0]   wr_cnt_reg;
  logic [WEI_ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [DATA_WIDTH-1:0]     rd_data_reg;
  logic                      inflight_reg;
  logic                      inflight_oor_reg;

  logic                      fill_hs;
  logic                      fill_done;
  logic                      adr_hs;
  logic                      adr_oor;
  logic                      leave_work;
  logic                      dat_vld;
  logic                      take;
  logic [1:0]                occ;
  logic [1:0]                occ_after;
  logic [DATA_WIDTH-1:0]     rd_val;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [1:0]                fifo_count;
  logic [DATA_WIDTH-1:0]     fifo_dout;

  assign WBFTOP_CfgRdy = (state_reg == IDLE);
  assign WBFGLB_DatRdy = (state_reg == FILL) && (wr_cnt_reg < fill_num_reg);
  assign fill_hs       = GLBWBF_DatVld & WBFGLB_DatRdy;
  assign fill_done     = ((fill_hs ? wr_cnt_reg + 1'b1 : wr_cnt_reg) == fill_num_reg);
  assign leave_work    = (state_reg == WORK) & TOPWBF_CfgVld;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (TOPWBF_CfgVld) state_next = FILL;
      FILL:    if (fill_done)     state_next = WORK;
      WORK:    if (TOPWBF_CfgVld) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fill_num_reg <= '0;
      wr_cnt_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && TOPWBF_CfgVld) begin
        fill_num_reg <= TOPWBF_CfgNum;
        wr_cnt_reg   <= '0;
        wr_ptr_reg   <= '0;
      end else if (fill_hs) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_hs) mem[wr_ptr_reg] <= GLBWBF_Dat;
    if (adr_hs)  rd_data_reg <= mem[WCAWBF_Adr];
  end

  // The read register acts as the stage ahead of the FIFO: when the FIFO is empty
  // its data is presented directly, which gives 1-cycle latency with no bubbles.
  assign occ        = {1'b0, inflight_reg} + fifo_count;
  assign dat_vld    = ~fifo_empty | inflight_reg;
  assign take       = dat_vld & WCAWBF_DatRdy;
  assign occ_after  = occ - {1'b0, take};
  assign WBFWCA_AdrRdy = (state_reg == WORK) && (occ_after < 2'd2);
  assign adr_hs     = WCAWBF_AdrVld & WBFWCA_AdrRdy;
  assign adr_oor    = ({1'b0, WCAWBF_Adr} >= fill_num_reg);

  assign rd_val     = inflight_oor_reg ? '0 : rd_data_reg;
  assign fifo_pop   = take & ~fifo_empty;
  assign fifo_push  = inflight_reg & ~(take & fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg     <= 1'b0;
      inflight_oor_reg <= 1'b0;
    end else if (leave_work) begin
      inflight_reg     <= 1'b0;
      inflight_oor_reg <= 1'b0;
    end else begin
      inflight_reg     <= adr_hs;
      inflight_oor_reg <= adr_hs & adr_oor;
    end
  end

  wei_buf_ofifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ofifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (leave_work),
    .din   (rd_val),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (fifo_dout)
  );

  assign WBFWCA_DatVld = dat_vld;
  assign WBFWCA_Dat    = !dat_vld ? '0 : (fifo_empty ? rd_val : fifo_dout);

endmodule

// File: tb/tb_wei_buf_rd.sv
// Directed self-checking bench for wei_buf_rd: fill, single reads from a vector
// table, streaming, backpressure, out-of-range, abort and asynchronous reset.
module tb_wei_buf_rd;

  logic       clk;
  logic       rst_n;
  logic       TOPWBF_CfgVld;
  logic [8:0] TOPWBF_CfgNum;
  logic       WBFTOP_CfgRdy;
  logic       GLBWBF_DatVld;
  logic [7:0] GLBWBF_Dat;
  logic       WBFGLB_DatRdy;
  logic       WCAWBF_AdrVld;
  logic [7:0] WCAWBF_Adr;
  logic       WBFWCA_AdrRdy;
  logic       WBFWCA_DatVld;
  logic [7:0] WBFWCA_Dat;
  logic       WCAWBF_DatRdy;

  wei_buf_rd dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .TOPWBF_CfgVld (TOPWBF_CfgVld),
    .TOPWBF_CfgNum (TOPWBF_CfgNum),
    .WBFTOP_CfgRdy (WBFTOP_CfgRdy),
    .GLBWBF_DatVld (GLBWBF_DatVld),
    .GLBWBF_Dat    (GLBWBF_Dat),
    .WBFGLB_DatRdy (WBFGLB_DatRdy),
    .WCAWBF_AdrVld (WCAWBF_AdrVld),
    .WCAWBF_Adr    (WCAWBF_Adr),
    .WBFWCA_AdrRdy (WBFWCA_AdrRdy),
    .WBFWCA_DatVld (WBFWCA_DatVld),
    .WBFWCA_Dat    (WBFWCA_Dat),
    .WCAWBF_DatRdy (WCAWBF_DatRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t    vecs [6];
  logic [7:0] fill_data [256];
  int         n_tests;
  int         n_fail;

  task automatic chk(input string nm, input string sub, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s.%s got=0x%0h want=0x%0h", nm, sub, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Configure from IDLE and push n words of fill_data; checks the FILL->WORK timing.
  task automatic fill(input int n);
    int w;
    TOPWBF_CfgVld = 1'b1;
    TOPWBF_CfgNum = 9'(n);
    @(negedge clk);
    chk("fill", "cfg_rdy", WBFTOP_CfgRdy, 1);
    step();
    TOPWBF_CfgVld = 1'b0;
    for (int i = 0; i < n; i++) begin
      GLBWBF_DatVld = 1'b1;
      GLBWBF_Dat    = fill_data[i];
      @(negedge clk);
      w = 0;
      while (!WBFGLB_DatRdy && w < 20) begin
        step();
        @(negedge clk);
        w++;
      end
      if (!WBFGLB_DatRdy) chk("fill", "dat_rdy_timeout", WBFGLB_DatRdy, 1);
      if (i == n - 1) chk("fill", "not_work_yet", WBFWCA_AdrRdy, 0);
      step();
    end
    GLBWBF_DatVld = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk("fill0", "fill_cycle_adr_rdy", WBFWCA_AdrRdy, 0);
      step();
    end
    @(negedge clk);
    chk("fill", "work_adr_rdy", WBFWCA_AdrRdy, 1);
    chk("fill", "work_dat_rdy", WBFGLB_DatRdy, 0);
    $display("[TB] fill n=%0d done", n);
    step();
  endtask

  task automatic go_idle();
    TOPWBF_CfgVld = 1'b1;
    step();
    TOPWBF_CfgVld = 1'b0;
  endtask

  // Single read with DatRdy high; data must be valid one cycle after the handshake.
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    int w;
    WCAWBF_AdrVld = 1'b1;
    WCAWBF_Adr    = a;
    @(negedge clk);
    w = 0;
    while (!WBFWCA_AdrRdy && w < 20) begin
      step();
      @(negedge clk);
      w++;
    end
    chk(nm, "adr_rdy", WBFWCA_AdrRdy, 1);
    step();
    WCAWBF_AdrVld = 1'b0;
    @(negedge clk);
    chk(nm, "dat_vld", WBFWCA_DatVld, 1);
    chk(nm, "dat", WBFWCA_Dat, exp);
    $display("[TB] read %s addr=0x%02h data=0x%02h", nm, a, WBFWCA_Dat);
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    TOPWBF_CfgVld = 1'b0;
    TOPWBF_CfgNum = '0;
    GLBWBF_DatVld = 1'b0;
    GLBWBF_Dat    = '0;
    WCAWBF_AdrVld = 1'b0;
    WCAWBF_Adr    = '0;
    WCAWBF_DatRdy = 1'b1;

    vecs[0] = '{8'd0,   8'h01};
    vecs[1] = '{8'd7,   8'h08};
    vecs[2] = '{8'd3,   8'h04};
    vecs[3] = '{8'd8,   8'h00};
    vecs[4] = '{8'd255, 8'h00};
    vecs[5] = '{8'd5,   8'h06};

    #2;
    chk("reset", "cfg_rdy", WBFTOP_CfgRdy, 1);
    chk("reset", "dat_rdy", WBFGLB_DatRdy, 0);
    chk("reset", "adr_rdy", WBFWCA_AdrRdy, 0);
    chk("reset", "dat_vld", WBFWCA_DatVld, 0);
    chk("reset", "dat", WBFWCA_Dat, 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic fill of four words and a single read.
    fill_data[0] = 8'h11; fill_data[1] = 8'h22; fill_data[2] = 8'h33; fill_data[3] = 8'h44;
    fill(4);
    rd(8'd2, 8'h33, "basic_rd2");

    // Eight-word fill (value = addr+1), then table-driven reads.
    go_idle();
    for (int i = 0; i < 256; i++) fill_data[i] = 8'(i + 1);
    fill(8);
    for (int i = 0; i < 6; i++) rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));

    // Streaming addresses 0..7 back to back.
    for (int i = 0; i < 8; i++) begin
      WCAWBF_AdrVld = 1'b1;
      WCAWBF_Adr    = 8'(i);
      @(negedge clk);
      chk($sformatf("stream%0d", i), "adr_rdy", WBFWCA_AdrRdy, 1);
      if (i > 0) begin
        chk($sformatf("stream%0d", i), "dat_vld", WBFWCA_DatVld, 1);
        chk($sformatf("stream%0d", i), "dat", WBFWCA_Dat, i);
        $display("[TB] stream beat data=0x%02h", WBFWCA_Dat);
      end
      step();
    end
    WCAWBF_AdrVld = 1'b0;
    @(negedge clk);
    chk("stream_last", "dat_vld", WBFWCA_DatVld, 1);
    chk("stream_last", "dat", WBFWCA_Dat, 8);
    step();
    @(negedge clk);
    chk("stream_end", "dat_vld", WBFWCA_DatVld, 0);
    step();

    // Backpressure: two accepts, then stall until DatRdy returns.
    WCAWBF_DatRdy = 1'b0;
    WCAWBF_AdrVld = 1'b1;
    WCAWBF_Adr    = 8'd0;
    @(negedge clk);
    chk("bp_acc0", "adr_rdy", WBFWCA_AdrRdy, 1);
    step();
    WCAWBF_Adr = 8'd1;
    @(negedge clk);
    chk("bp_acc1", "adr_rdy", WBFWCA_AdrRdy, 1);
    step();
    WCAWBF_Adr = 8'd2;
    @(negedge clk);
    chk("bp_stall", "adr_rdy", WBFWCA_AdrRdy, 0);
    chk("bp_stall", "dat", WBFWCA_Dat, 8'h01);
    step();
    @(negedge clk);
    chk("bp_stall2", "adr_rdy", WBFWCA_AdrRdy, 0);
    step();
    WCAWBF_DatRdy = 1'b1;
    @(negedge clk);
    chk("bp_release", "adr_rdy", WBFWCA_AdrRdy, 1);
    chk("bp_release", "dat", WBFWCA_Dat, 8'h01);
    step();
    WCAWBF_AdrVld = 1'b0;
    @(negedge clk);
    chk("bp_d2", "dat_vld", WBFWCA_DatVld, 1);
    chk("bp_d2", "dat", WBFWCA_Dat, 8'h02);
    step();
    @(negedge clk);
    chk("bp_d3", "dat_vld", WBFWCA_DatVld, 1);
    chk("bp_d3", "dat", WBFWCA_Dat, 8'h03);
    step();
    @(negedge clk);
    chk("bp_end", "dat_vld", WBFWCA_DatVld, 0);
    step();

    // Out-of-range reads with fill_num = 4.
    go_idle();
    fill(4);
    rd(8'd10, 8'h00, "oor_rd10");
    rd(8'd3,  8'h04, "oor_rd3");
    rd(8'd5,  8'h00, "oor_rd5_stale");

    // Abort with two entries buffered.
    WCAWBF_DatRdy = 1'b0;
    WCAWBF_AdrVld = 1'b1;
    WCAWBF_Adr    = 8'd0;
    step();
    WCAWBF_Adr = 8'd1;
    step();
    WCAWBF_AdrVld = 1'b0;
    @(negedge clk);
    chk("abort_pre", "dat_vld", WBFWCA_DatVld, 1);
    step();
    TOPWBF_CfgVld = 1'b1;
    @(negedge clk);
    chk("abort_pre", "adr_rdy_full", WBFWCA_AdrRdy, 0);
    step();
    TOPWBF_CfgVld = 1'b0;
    @(negedge clk);
    chk("abort", "dat_vld", WBFWCA_DatVld, 0);
    chk("abort", "cfg_rdy", WBFTOP_CfgRdy, 1);
    chk("abort", "adr_rdy", WBFWCA_AdrRdy, 0);
    step();
    WCAWBF_DatRdy = 1'b1;
    fill(0);
    rd(8'd0, 8'h00, "empty_rd0");
    rd(8'd1, 8'h00, "empty_rd1");

    // Asynchronous reset after three of six fill words.
    go_idle();
    TOPWBF_CfgVld = 1'b1;
    TOPWBF_CfgNum = 9'd6;
    step();
    TOPWBF_CfgVld = 1'b0;
    GLBWBF_DatVld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      GLBWBF_Dat = fill_data[i];
      step();
    end
    @(negedge clk);
    chk("midfill", "dat_rdy", WBFGLB_DatRdy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", "cfg_rdy", WBFTOP_CfgRdy, 1);
    chk("async_rst", "dat_rdy", WBFGLB_DatRdy, 0);
    chk("async_rst", "adr_rdy", WBFWCA_AdrRdy, 0);
    chk("async_rst", "dat_vld", WBFWCA_DatVld, 0);
    chk("async_rst", "dat", WBFWCA_Dat, 0);
    GLBWBF_DatVld = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
